// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller types and constants.
// State encodings, fault codes and the default boot address.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-issue fetch master: one AXI4-Lite read per instruction,
// hands the word to decode, then waits for the next PC from writeback.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] npc,
  input  logic        npc_valid
);

  state_t      state;
  state_t      nxt;
  logic [31:0] pc;
  logic        npc_pend;
  logic [31:0] pend_pc;
  logic        take;
  logic [31:0] tgt;
  logic        misal;

  assign araddr = pc;

  // A live pulse is newer than anything latched, so it wins.
  assign take  = npc_valid || npc_pend;
  assign tgt   = npc_valid ? npc : pend_pc;
  assign misal = tgt[1:0] != 2'b00;

  always_comb begin
    nxt = state;
    unique case (state)
      S_REQ:  if (arvalid && arready) nxt = S_RESP;
      S_RESP: if (rvalid && rready) nxt = S_OUT;
      S_OUT:  if (inst_ready) nxt = S_WAIT;
      S_WAIT: if (take) nxt = misal ? S_OUT : S_REQ;
      default: nxt = S_REQ;
    endcase
  end

  // Handshake flags are registered copies of the next state so they
  // stay low through reset and rise the cycle after it is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= ERR_NONE;
      npc_pend   <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= nxt;
      arvalid    <= nxt == S_REQ;
      rready     <= nxt == S_RESP;
      inst_valid <= nxt == S_OUT;

      if (state == S_WAIT) begin
        npc_pend <= 1'b0;
      end else if (npc_valid) begin
        npc_pend <= 1'b1;
        pend_pc  <= npc;
      end

      if (state == S_RESP && rvalid && rready) begin
        inst     <= (rresp == RESP_ERR) ? 32'h0 : rdata;
        inst_err <= (rresp == RESP_ERR) ? ERR_BUS : ERR_NONE;
        inst_pc  <= pc;
      end

      if (state == S_WAIT && take) begin
        pc <= tgt;
        if (misal) begin
          inst     <= '0;
          inst_err <= ERR_MISALIGN;
          inst_pc  <= tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl.
// Hand-computed vectors covering reset, fetch, stalls and faults.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] npc;
  logic        npc_valid;

  int checks = 0;
  int errors = 0;
  int ar_hs  = 0;
  int hs0;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_err   (inst_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .npc        (npc),
    .npc_valid  (npc_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_npc(input logic [31:0] a);
    npc       = a;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
  endtask

  task automatic ar_go();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic e);
    rdata  = d;
    rresp  = e;
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    rresp  = 1'b0;
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    arready    = 1'b0;
    rdata      = '0;
    rresp      = 1'b0;
    rvalid     = 1'b0;
    inst_ready = 1'b0;
    npc        = '0;
    npc_valid  = 1'b0;

    repeat (3) tick();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_ivalid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ipc", inst_pc, 32'h0);
    chk("rst_ierr", 32'(inst_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("boot_arvalid", 32'(arvalid), 32'd1);
    chk("boot_araddr", araddr, 32'h8000_0000);

    // normal fetch
    ar_go();
    chk("n_rready", 32'(rready), 32'd1);
    chk("n_arvalid", 32'(arvalid), 32'd0);
    r_beat(32'h0000_0413, 1'b0);
    chk("n_ivalid", 32'(inst_valid), 32'd1);
    chk("n_inst", inst, 32'h0000_0413);
    chk("n_ipc", inst_pc, 32'h8000_0000);
    chk("n_ierr", 32'(inst_err), 32'd0);
    accept();
    chk("w_ivalid", 32'(inst_valid), 32'd0);
    chk("w_arvalid", 32'(arvalid), 32'd0);
    pulse_npc(32'h8000_0004);
    chk("n2_arvalid", 32'(arvalid), 32'd1);
    chk("n2_araddr", araddr, 32'h8000_0004);

    // backpressure on every channel
    hs0 = ar_hs;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_arvalid", 32'(arvalid), 32'd1);
      chk("bp_araddr", araddr, 32'h8000_0004);
    end
    ar_go();
    for (int i = 0; i < 3; i++) begin
      chk("bp_rready", 32'(rready), 32'd1);
      chk("bp_noar", 32'(arvalid), 32'd0);
      tick();
    end
    r_beat(32'h1234_5678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ivalid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'h1234_5678);
      chk("bp_ipc", inst_pc, 32'h8000_0004);
      tick();
    end
    chk("bp_one_ar", 32'(ar_hs - hs0), 32'd1);
    accept();

    // bus error
    pulse_npc(32'h8000_0008);
    ar_go();
    r_beat(32'hDEAD_BEEF, 1'b1);
    chk("be_ivalid", 32'(inst_valid), 32'd1);
    chk("be_inst", inst, 32'h0);
    chk("be_ierr", 32'(inst_err), 32'd1);
    chk("be_ipc", inst_pc, 32'h8000_0008);
    accept();

    // misaligned target never reaches the bus
    hs0 = ar_hs;
    pulse_npc(32'h8000_0002);
    chk("ma_arvalid", 32'(arvalid), 32'd0);
    chk("ma_ivalid", 32'(inst_valid), 32'd1);
    chk("ma_ierr", 32'(inst_err), 32'd2);
    chk("ma_ipc", inst_pc, 32'h8000_0002);
    chk("ma_inst", inst, 32'h0);
    accept();
    chk("ma_no_ar", 32'(ar_hs - hs0), 32'd0);

    // early npc during RESP is consumed on WAIT entry
    pulse_npc(32'h8000_000C);
    ar_go();
    pulse_npc(32'h8000_0010);
    r_beat(32'h0000_00AA, 1'b0);
    chk("pe_ipc", inst_pc, 32'h8000_000C);
    chk("pe_inst", inst, 32'h0000_00AA);
    accept();
    chk("pe_wait", 32'(arvalid), 32'd0);
    tick();
    chk("pe_arvalid", 32'(arvalid), 32'd1);
    chk("pe_araddr", araddr, 32'h8000_0010);

    // reset in OUT drops the pending npc
    ar_go();
    r_beat(32'h0000_00BB, 1'b0);
    pulse_npc(32'h8000_0020);
    chk("ro_ivalid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ro_arvalid", 32'(arvalid), 32'd0);
    chk("ro_ivalid0", 32'(inst_valid), 32'd0);
    chk("ro_inst", inst, 32'h0);
    tick();
    chk("ro_arvalid1", 32'(arvalid), 32'd1);
    chk("ro_araddr", araddr, 32'h8000_0000);
    ar_go();
    r_beat(32'h0000_00CC, 1'b0);
    accept();
    tick();
    chk("ro_nopend", 32'(arvalid), 32'd0);
    chk("ro_nopend_iv", 32'(inst_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule
